// File: rtl/display_pkg.sv
// Shared definitions for the decimal display path: segment encodings,
// digit pattern table, BCD sizing helpers and the controller state type.
package display_pkg;

    // Segment order {A,B,C,D,E,F,G}, active-high.
    localparam logic [6:0] SEG_DASH  = 7'h01;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Index 0 is the rightmost element.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B,
        7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_COMMIT
    } disp_state_e;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
        if (nib <= 4'd9) begin
            return SEG_DIGITS[nib];
        end
        return SEG_BLANK;
    endfunction

    // ceil(w * log10(2)) using a fixed-point approximation of log10(2).
    function automatic int unsigned bcd_digits(input int unsigned w);
        return (w * 30103 + 99999) / 100000;
    endfunction

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bin_to_bcd_serial.sv
// Serial double-dabble converter: one shift-add-3 step per clock,
// VALUE_WIDTH steps per conversion. done flags the final step.
module bin_to_bcd_serial
    import display_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH = 32,
    parameter int unsigned BCD_DIGITS  = 10
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    start,
    input  logic [VALUE_WIDTH-1:0]  value,
    output logic                    busy,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);
    localparam int unsigned BCD_W = 4 * BCD_DIGITS;
    localparam int unsigned CNT_W = $clog2(VALUE_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(VALUE_WIDTH - 1);

    logic [BCD_W-1:0]       bcd_q, bcd_adj;
    logic [VALUE_WIDTH-1:0] bin_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   busy_q;

    // Add-3 correction on every nibble that would reach 10 after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Capture on start, then shift {bcd,bin} left once per clock.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bcd_q  <= '0;
            bin_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (start && !busy_q) begin
            bcd_q  <= '0;
            bin_q  <= value;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
            cnt_q          <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done = busy_q && (cnt_q == LAST);
    assign busy = busy_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/decimal_display_scanner.sv
// Decimal display stage: serial binary-to-BCD conversion of a captured
// value, committed to per-digit segment registers and scanned out on a
// multiplexed seven-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module decimal_display_scanner
    import display_pkg::*;
#(
    parameter int unsigned VALUE_WIDTH  = 32,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned SCAN_DIV_BIT = 14
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [VALUE_WIDTH-1:0] value,
    input  logic                   valid,
    input  logic                   load,
    output logic                   busy,
    output logic                   overflow,
    output logic [DIGITS-1:0]      digit_sel,
    output logic [6:0]             seg
);
    localparam int unsigned BCD_DIGITS = bcd_digits(VALUE_WIDTH);
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned PAD_DIGITS = (DIGITS > BCD_DIGITS) ? DIGITS : BCD_DIGITS;
    localparam int unsigned PAD_W      = 4 * PAD_DIGITS;
    localparam logic [63:0] OVF_LIMIT  = pow10(DIGITS);

    disp_state_e             state_q, state_d;
    logic                    conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0]        conv_bcd;
    logic [PAD_W-1:0]        bcd_pad;
    logic                    upper_nz;
    logic                    valid_q, ovf_q, overflow_q;
    logic [DIGITS-1:0][6:0]  disp_q, disp_commit;
    logic [3:0]              nib;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    seen_nz;
`endif
    logic [SCAN_DIV_BIT-1:0] scan_cnt_q;
    logic [DIGITS-1:0]       sel_q, sel_d;
    logic [6:0]              seg_q, seg_d;

    bin_to_bcd_serial #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .BCD_DIGITS  (BCD_DIGITS)
    ) u_conv (
        .CLK   (CLK),
        .RST   (RST),
        .start (conv_start),
        .value (value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign bcd_pad = PAD_W'(conv_bcd);

    // Any nonzero digit beyond the display width also forces dashes; this is
    // redundant with the overflow compare but keeps every BCD bit observed.
    if (PAD_DIGITS > DIGITS) begin : g_upper
        assign upper_nz = |bcd_pad[PAD_W-1:4*DIGITS];
    end else begin : g_no_upper
        assign upper_nz = 1'b0;
    end

    // Controller state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; load is only honoured in IDLE.
    always_comb begin
        state_d    = state_q;
        conv_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    conv_start = 1'b1;
                    state_d    = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Segment image to be committed, scanned from the most significant digit.
    always_comb begin
        disp_commit = {DIGITS{SEG_DASH}};
        nib         = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
        seen_nz     = 1'b0;
`endif
        if (valid_q && !ovf_q && !upper_nz) begin
            for (int unsigned j = 0; j < DIGITS; j++) begin
                nib = bcd_pad[4*(DIGITS-1-j) +: 4];
                disp_commit[DIGITS-1-j] = bcd_to_seg(nib);
`ifdef LEADING_ZERO_BLANK_EN
                if (nib != 4'd0) begin
                    seen_nz = 1'b1;
                end
                if (!seen_nz && (j != DIGITS-1)) begin
                    disp_commit[DIGITS-1-j] = SEG_BLANK;
                end
`endif
            end
        end
    end

    // Capture flags on load; update display and overflow on commit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            disp_q     <= {DIGITS{SEG_DASH}};
        end else begin
            if (conv_start) begin
                valid_q <= valid;
                ovf_q   <= (64'(value) >= OVF_LIMIT);
            end
            if (state_q == ST_COMMIT) begin
                overflow_q <= valid_q & ovf_q;
                disp_q     <= disp_commit;
            end
        end
    end

    // Next digit select and the segment pattern that goes with it.
    always_comb begin
        sel_d = sel_q;
        if (scan_cnt_q == '1) begin
            sel_d = (sel_q << 1) | (sel_q >> (DIGITS - 1));
        end
        seg_d = SEG_BLANK;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (sel_d[k]) begin
                seg_d = disp_q[k];
            end
        end
    end

    // Free-running scan divider, digit select and registered segments.
    always_ff @(posedge CLK) begin
        if (RST) begin
            scan_cnt_q <= '0;
            sel_q      <= DIGITS'(1);
            seg_q      <= SEG_DASH;
        end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
            sel_q      <= sel_d;
            seg_q      <= seg_d;
        end
    end

    assign busy      = (state_q != ST_IDLE) || conv_busy;
    assign overflow  = overflow_q;
    assign digit_sel = sel_q;
    assign seg       = seg_q;

endmodule
